// File: rtl/demux_4bit_dos_canales_pkg.sv
// Shared definitions for the two-channel nibble demultiplexer.
// Provides the channel select encoding and the default geometry.
package demux_pkg;

    localparam logic CH_A = 1'b0;
    localparam logic CH_B = 1'b1;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_DEPTH = 2;

endpackage

// File: rtl/demux_4bit_dos_canales_if.sv
// Bus bundle between the nibble source, the demultiplexer and the two
// filter lanes. The master side drives the input word and the lane
// readies; the slave side (the demultiplexer) drives everything else.
// DEMUX_ALTERNATE_EN adds the in_alt strobe.
interface demux_4bit_dos_canales_if
    import demux_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] in_data;
    logic             in_sel;
    logic             in_valid;
    logic             in_ready;
`ifdef DEMUX_ALTERNATE_EN
    logic             in_alt;
`endif
    logic [WIDTH-1:0] a_data;
    logic             a_valid;
    logic             a_ready;
    logic [WIDTH-1:0] b_data;
    logic             b_valid;
    logic             b_ready;
    logic [PTR_W:0]   a_count;
    logic [PTR_W:0]   b_count;

    modport master (
`ifdef DEMUX_ALTERNATE_EN
        output in_alt,
`endif
        output in_data, in_sel, in_valid, a_ready, b_ready,
        input  in_ready, a_data, a_valid, b_data, b_valid, a_count, b_count
    );

    modport slave (
`ifdef DEMUX_ALTERNATE_EN
        input  in_alt,
`endif
        input  in_data, in_sel, in_valid, a_ready, b_ready,
        output in_ready, a_data, a_valid, b_data, b_valid, a_count, b_count
    );

endinterface

// File: rtl/demux_4bit_dos_canales_fifo.sv
// Small synchronous FIFO holding one channel's nibbles. The head entry is
// presented directly from storage; storage is cleared on reset so the head
// reads zero while empty after reset. Pushes when full and pops when empty
// are ignored.
module nibble_fifo
    import demux_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [PTR_W:0]   count
);

    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
    localparam logic [PTR_W:0]   CNT_ONE   = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0]   CNT_FULL  = (PTR_W + 1)'(DEPTH);

    // Pointer advance; DEPTH is a power of two so the wrap is natural.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return p + PTR_ONE;
    endfunction

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W:0]   count_r;
    logic             push_ok_s;
    logic             pop_ok_s;
    logic             full_s;
    logic             empty_s;

    // Occupancy flags and qualified push/pop strobes.
    always_comb begin
        full_s    = (count_r == CNT_FULL);
        empty_s   = (count_r == '0);
        push_ok_s = push & ~full_s;
        pop_ok_s  = pop & ~empty_s;
    end

    // Storage, pointers and occupancy count.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= wdata;
                wr_ptr_r        <= ptr_inc(wr_ptr_r);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    assign rdata = mem_r[rd_ptr_r];
    assign full  = full_s;
    assign empty = empty_s;
    assign count = count_r;

endmodule

// File: rtl/demux_4bit_dos_canales.sv
// Registered 1-to-2 nibble demultiplexer. Each accepted input word is
// steered into channel A or B's FIFO; both channels drain independently.
// Optional feature macro: DEMUX_ALTERNATE_EN -- adds in_alt, which steers
// words alternately A, B, A, ... from an internal toggle instead of in_sel.
module demux_4bit_dos_canales
    import demux_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic                       clk,
    input  logic                       reset,
    demux_4bit_dos_canales_if.slave    bus
);

    logic             eff_sel_s;
    logic             in_ready_s;
    logic             accept_s;
    logic             push_a_s;
    logic             push_b_s;
    logic             pop_a_s;
    logic             pop_b_s;
    logic             a_full_s;
    logic             a_empty_s;
    logic             b_full_s;
    logic             b_empty_s;
    logic [WIDTH-1:0] a_rdata_s;
    logic [WIDTH-1:0] b_rdata_s;
    logic [PTR_W:0]   a_count_s;
    logic [PTR_W:0]   b_count_s;

`ifdef DEMUX_ALTERNATE_EN
    logic toggle_r;

    // Alternation target: flips on every word accepted while in_alt is high.
    always_ff @(posedge clk) begin
        if (reset) begin
            toggle_r <= CH_A;
        end else if (accept_s && bus.in_alt) begin
            toggle_r <= ~toggle_r;
        end
    end

    // Effective target: toggle while alternating, in_sel otherwise.
    always_comb begin
        if (bus.in_alt) begin
            eff_sel_s = toggle_r;
        end else begin
            eff_sel_s = bus.in_sel;
        end
    end
`else
    // Effective target comes straight from in_sel.
    always_comb begin
        eff_sel_s = bus.in_sel;
    end
`endif

    // Ready depends only on the target's full flag, never on lane readies.
    always_comb begin
        if (eff_sel_s == CH_B) begin
            in_ready_s = ~b_full_s;
        end else begin
            in_ready_s = ~a_full_s;
        end
        accept_s = bus.in_valid & in_ready_s;
        push_a_s = accept_s & (eff_sel_s == CH_A);
        push_b_s = accept_s & (eff_sel_s == CH_B);
        pop_a_s  = ~a_empty_s & bus.a_ready;
        pop_b_s  = ~b_empty_s & bus.b_ready;
    end

    nibble_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_a (
        .clk   (clk),
        .reset (reset),
        .push  (push_a_s),
        .pop   (pop_a_s),
        .wdata (bus.in_data),
        .rdata (a_rdata_s),
        .full  (a_full_s),
        .empty (a_empty_s),
        .count (a_count_s)
    );

    nibble_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_b (
        .clk   (clk),
        .reset (reset),
        .push  (push_b_s),
        .pop   (pop_b_s),
        .wdata (bus.in_data),
        .rdata (b_rdata_s),
        .full  (b_full_s),
        .empty (b_empty_s),
        .count (b_count_s)
    );

    assign bus.in_ready = in_ready_s;
    assign bus.a_data   = a_rdata_s;
    assign bus.a_valid  = ~a_empty_s;
    assign bus.a_count  = a_count_s;
    assign bus.b_data   = b_rdata_s;
    assign bus.b_valid  = ~b_empty_s;
    assign bus.b_count  = b_count_s;

endmodule
